request_conditioner: RTL and testbench
======================================

REQUEST_CONDITIONER -- requirements
Module: request_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples needed to accept a pedestrian button level change (range 1..15).
REQ-002 Parameter PRESENCE_CYCLES, default 8: consecutive synchronized samples needed to set or clear vehicle presence (range 1..255).
REQ-003 Parameter ACK_HOLD, default 2: consecutive red cycles on a road needed to mark its walk request served (range 1..15).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 rawWalkTv, rawWalkNN, rawWalkNS  input  1 each  asynchronous pedestrian push-buttons, high = pressed.
REQ-007 rawCarTv, rawCarNN, rawCarNS  input  1 each  asynchronous inductive-loop vehicle detectors, high = vehicle.
REQ-008 lightTv, lightNN, lightNS  input  2 each  controller lamp state: 2'b00 red, 2'b01 yellow, 2'b10 green, 2'b11 invalid.
REQ-009 trafficSensorTv, trafficSensorNN, trafficSensorNS  output  1 each  filtered vehicle presence to the controller.
REQ-010 walkRequestTv, walkRequestNN, walkRequestNS  output  1 each  latched pedestrian request to the controller.
REQ-011 walkServed  output  3  one-cycle pulse per road, bit0 Tv, bit1 NN, bit2 NS.
REQ-012 servedCount  output  8  total walk requests served since reset, saturating.

Function
REQ-013 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic; t0 denotes the first clk edge sampling a new raw level.
REQ-014 Button debounce: per-channel counter; stable level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differing from current stable level; any agreeing sample clears counter.
REQ-015 Debounced stable level SHALL update on edge t0+1+DEBOUNCE_CYCLES for a clean level change (t0+5 at default).
REQ-016 Pulses shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change in any output.
REQ-017 Per-road walk FSM states: IDLE, PENDING, SERVING; encoding is implementer's choice.
REQ-018 IDLE -> PENDING on debounced rising edge of that road's button; walkRequest rises on edge t0+2+DEBOUNCE_CYCLES (t0+6 at default).
REQ-019 PENDING -> SERVING when that road's light == 2'b00; hold counter starts at 1 on that edge.
REQ-020 SERVING: counter increments each cycle light stays 2'b00; on reaching ACK_HOLD -> IDLE, walkServed bit pulses high for exactly that one cycle.
REQ-021 SERVING -> PENDING if light leaves 2'b00 before ACK_HOLD reached; hold counter cleared.
REQ-022 walkRequest output SHALL be high in PENDING and SERVING, low in IDLE, registered (no combinational path from inputs).
REQ-023 Button presses while PENDING or SERVING SHALL be merged (no second request); a press debounced on the same edge the FSM returns to IDLE starts a new request next cycle.
REQ-024 Light code 2'b11 SHALL be treated as not red.
REQ-025 Vehicle presence: per-channel 8-bit counter; trafficSensor sets after PRESENCE_CYCLES consecutive synchronized highs, clears after PRESENCE_CYCLES consecutive lows (hysteresis); output updates on edge t0+1+PRESENCE_CYCLES (t0+9 at default).
REQ-026 servedCount SHALL add the popcount of walkServed each cycle (0..3), saturating at 255.
REQ-027 All three roads SHALL operate fully independently; simultaneous events on all roads handled in the same cycle.

Reset
REQ-028 While reset is high on a clk edge: all outputs 0, all FSMs IDLE, all counters 0, synchronizer flops 0, stable debounced levels 0.
REQ-029 Reset asserted mid-operation SHALL discard pending requests without a walkServed pulse; a button held through reset release is seen as a new rising edge after debounce.

Verification
REQ-030 rawWalkNN high from t0, lightNN=2'b10 -> walkRequestNN=1 at t0+6, stays 1, walkServed=0.
REQ-031 Then lightNN=2'b00 for 2 cycles -> walkServed[1] single pulse on 2nd red edge, walkRequestNN=0 next cycle, servedCount=1.
REQ-032 rawWalkTv glitch high 3 cycles -> walkRequestTv stays 0; rawCarTv high 7 cycles then low -> trafficSensorTv stays 0.
REQ-033 rawCarNS high from t0 -> trafficSensorNS=1 at t0+9; low from t1 -> 0 at t1+9; single-cycle low dropout inside ignored.
REQ-034 All three requests pending, all lights 2'b00 two cycles -> walkServed=3'b111 one cycle, servedCount +3; preset 254 -> saturates 255.
REQ-035 Reset pulse while walkRequestNS=1 in SERVING -> all outputs 0 next edge, no walkServed pulse.

Source files
------------

// File: rtl/request_conditioner.sv
// Conditions pedestrian buttons and vehicle loops for three roads: synchronize,
// debounce/filter, and track each walk request until its road has been red long enough.
module request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESENCE_CYCLES = 8,
  parameter int ACK_HOLD        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rawWalkTv,
  input  logic       rawWalkNN,
  input  logic       rawWalkNS,
  input  logic       rawCarTv,
  input  logic       rawCarNN,
  input  logic       rawCarNS,
  input  logic [1:0] lightTv,
  input  logic [1:0] lightNN,
  input  logic [1:0] lightNS,
  output logic       trafficSensorTv,
  output logic       trafficSensorNN,
  output logic       trafficSensorNS,
  output logic       walkRequestTv,
  output logic       walkRequestNN,
  output logic       walkRequestNS,
  output logic [2:0] walkServed,
  output logic [7:0] servedCount
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_SERVING = 2'b10
  } walk_state_t;

  logic [5:0]  w_raw;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic [3:0]  r_btn_cnt [3];
  logic [2:0]  r_btn_stable;
  logic [2:0]  r_btn_stable_d;
  logic [7:0]  r_car_cnt [3];
  logic [2:0]  r_car_stable;
  logic [1:0]  w_light [3];
  logic [2:0]  w_red;
  logic [2:0]  w_rise;
  walk_state_t r_state [3];
  walk_state_t w_state_nxt [3];
  logic [3:0]  r_hold [3];
  logic [3:0]  w_hold_nxt [3];
  logic [2:0]  w_served_nxt;
  logic [2:0]  r_walk_req;
  logic [2:0]  w_walk_req_nxt;
  logic [2:0]  r_served;
  logic [7:0]  r_count;
  logic [8:0]  w_sum;

  // bit order everywhere: 0 Tv, 1 NN, 2 NS; cars occupy raw bits 5:3
  assign w_raw   = {rawCarNS, rawCarNN, rawCarTv, rawWalkNS, rawWalkNN, rawWalkTv};
  assign w_light[0] = lightTv;
  assign w_light[1] = lightNN;
  assign w_light[2] = lightNS;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_red[i]  = (w_light[i] == 2'b00);
      w_rise[i] = r_btn_stable[i] & ~r_btn_stable_d[i];
    end
  end

  // synchronizers, button debounce and vehicle presence filters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1        <= 6'd0;
      r_sync2        <= 6'd0;
      r_btn_stable   <= 3'd0;
      r_btn_stable_d <= 3'd0;
      r_car_stable   <= 3'd0;
      for (int i = 0; i < 3; i++) begin
        r_btn_cnt[i] <= 4'd0;
        r_car_cnt[i] <= 8'd0;
      end
    end else begin
      r_sync1        <= w_raw;
      r_sync2        <= r_sync1;
      r_btn_stable_d <= r_btn_stable;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_btn_stable[i]) begin
          r_btn_cnt[i] <= 4'd0;
        end else if (r_btn_cnt[i] == 4'(DEBOUNCE_CYCLES - 1)) begin
          r_btn_stable[i] <= r_sync2[i];
          r_btn_cnt[i]    <= 4'd0;
        end else begin
          r_btn_cnt[i] <= r_btn_cnt[i] + 4'd1;
        end
        if (r_sync2[i+3] == r_car_stable[i]) begin
          r_car_cnt[i] <= 8'd0;
        end else if (r_car_cnt[i] == 8'(PRESENCE_CYCLES - 1)) begin
          r_car_stable[i] <= r_sync2[i+3];
          r_car_cnt[i]    <= 8'd0;
        end else begin
          r_car_cnt[i] <= r_car_cnt[i] + 8'd1;
        end
      end
    end
  end

  // per-road walk request next-state; a press arriving while busy is absorbed
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_hold_nxt[i]   = r_hold[i];
      w_served_nxt[i] = 1'b0;
      case (r_state[i])
        ST_IDLE: begin
          if (w_rise[i]) begin
            w_state_nxt[i] = ST_PENDING;
            w_hold_nxt[i]  = 4'd0;
          end else begin
            w_hold_nxt[i] = 4'd0;
          end
        end
        ST_PENDING: begin
          if (w_red[i] && (ACK_HOLD == 1)) begin
            w_state_nxt[i]  = ST_IDLE;
            w_served_nxt[i] = 1'b1;
            w_hold_nxt[i]   = 4'd0;
          end else if (w_red[i]) begin
            w_state_nxt[i] = ST_SERVING;
            w_hold_nxt[i]  = 4'd1;
          end else begin
            w_hold_nxt[i] = 4'd0;
          end
        end
        ST_SERVING: begin
          if (!w_red[i]) begin
            w_state_nxt[i] = ST_PENDING;
            w_hold_nxt[i]  = 4'd0;
          end else if ((r_hold[i] + 4'd1) == 4'(ACK_HOLD)) begin
            w_state_nxt[i]  = ST_IDLE;
            w_served_nxt[i] = 1'b1;
            w_hold_nxt[i]   = 4'd0;
          end else begin
            w_hold_nxt[i] = r_hold[i] + 4'd1;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_hold_nxt[i]  = 4'd0;
        end
      endcase
      w_walk_req_nxt[i] = (w_state_nxt[i] != ST_IDLE);
    end
  end

  assign w_sum = {1'b0, r_count} + 9'(w_served_nxt[0]) + 9'(w_served_nxt[1])
               + 9'(w_served_nxt[2]);

  // walk FSM state, registered request/served outputs and saturating served counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_walk_req <= 3'd0;
      r_served   <= 3'd0;
      r_count    <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= ST_IDLE;
        r_hold[i]  <= 4'd0;
      end
    end else begin
      r_walk_req <= w_walk_req_nxt;
      r_served   <= w_served_nxt;
      r_count    <= w_sum[8] ? 8'd255 : w_sum[7:0];
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
      end
    end
  end

  assign trafficSensorTv = r_car_stable[0];
  assign trafficSensorNN = r_car_stable[1];
  assign trafficSensorNS = r_car_stable[2];
  assign walkRequestTv   = r_walk_req[0];
  assign walkRequestNN   = r_walk_req[1];
  assign walkRequestNS   = r_walk_req[2];
  assign walkServed      = r_served;
  assign servedCount     = r_count;

endmodule

// File: tb/tb_request_conditioner.sv
// Bench for request_conditioner: directed literal checks plus randomized traffic,
// all compared every cycle against a sample-window reference model.
module tb_request_conditioner;

  localparam int D = 4;
  localparam int P = 8;
  localparam int A = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] walk = 3'd0;
  logic [2:0] car  = 3'd0;
  logic [1:0] lt [3];
  logic       sTv, sNN, sNS, rTv, rNN, rNS;
  logic [2:0] served;
  logic [7:0] count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  request_conditioner #(.DEBOUNCE_CYCLES(D), .PRESENCE_CYCLES(P), .ACK_HOLD(A)) dut (
    .clk(clk), .reset(reset),
    .rawWalkTv(walk[0]), .rawWalkNN(walk[1]), .rawWalkNS(walk[2]),
    .rawCarTv(car[0]), .rawCarNN(car[1]), .rawCarNS(car[2]),
    .lightTv(lt[0]), .lightNN(lt[1]), .lightNS(lt[2]),
    .trafficSensorTv(sTv), .trafficSensorNN(sNN), .trafficSensorNS(sNS),
    .walkRequestTv(rTv), .walkRequestNN(rNN), .walkRequestNS(rNS),
    .walkServed(served), .servedCount(count)
  );

  always #5 clk = ~clk;

  // reference model: raw level seen two edges late, stable level flips once the
  // last N samples all disagree with it; requests count consecutive red edges
  bit         m_rawq [6][$];
  bit         m_samp [6][$];
  bit         m_st [6];
  bit         m_st_old [3];
  bit         m_rise [3];
  bit         m_raw_now [6];
  bit         m_req [3];
  int         m_run [3];
  bit [2:0]   m_served;
  int         m_count;
  bit         m_diff;
  int         m_thr;

  always @(posedge clk) begin
    m_raw_now = '{walk[0], walk[1], walk[2], car[0], car[1], car[2]};
    if (reset) begin
      for (int c = 0; c < 6; c++) begin
        m_rawq[c].delete();
        m_rawq[c].push_back(1'b0);
        m_rawq[c].push_back(1'b0);
        m_samp[c].delete();
        m_st[c] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        m_st_old[i] = 1'b0;
        m_req[i] = 1'b0;
        m_run[i] = 0;
      end
      m_served = 3'd0;
      m_count  = 0;
    end else begin
      for (int i = 0; i < 3; i++) m_rise[i] = m_st[i] & ~m_st_old[i];
      for (int i = 0; i < 3; i++) m_st_old[i] = m_st[i];
      for (int c = 0; c < 6; c++) begin
        m_samp[c].push_back(m_rawq[c][0]);
        void'(m_rawq[c].pop_front());
        m_rawq[c].push_back(m_raw_now[c]);
        if (m_samp[c].size() > 300) void'(m_samp[c].pop_front());
        m_thr = (c < 3) ? D : P;
        if (m_samp[c].size() >= m_thr) begin
          m_diff = 1'b1;
          for (int k = 0; k < m_thr; k++)
            if (m_samp[c][m_samp[c].size() - 1 - k] == m_st[c]) m_diff = 1'b0;
          if (m_diff) m_st[c] = ~m_st[c];
        end
      end
      for (int i = 0; i < 3; i++) begin
        m_served[i] = 1'b0;
        if (!m_req[i]) begin
          if (m_rise[i]) begin
            m_req[i] = 1'b1;
            m_run[i] = 0;
          end
        end else if (lt[i] == 2'b00) begin
          m_run[i]++;
          if (m_run[i] >= A) begin
            m_req[i] = 1'b0;
            m_served[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_count = m_count + m_served[0] + m_served[1] + m_served[2];
      if (m_count > 255) m_count = 255;
    end
  end

  logic [16:0] dut_vec, mdl_vec;
  assign dut_vec = {sNS, sNN, sTv, rNS, rNN, rTv, served, count};

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      mdl_vec = {m_st[5], m_st[4], m_st[3], m_req[2], m_req[1], m_req[0], m_served, 8'(m_count)};
      tests++;
      if (dut_vec !== mdl_vec) begin
        fails++;
        $display("FAIL model_cmp t=%0t: got %h expected %h", $time, dut_vec, mdl_vec);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_lights(input logic [1:0] v);
    for (int i = 0; i < 3; i++) lt[i] = v;
  endtask

  task automatic serve_round(input logic [2:0] mask);
    @(negedge clk); walk = mask;
    tick(8);
    @(negedge clk); walk = 3'd0;
    tick(8);
    @(negedge clk); set_lights(2'b00);
    tick(3);
    @(negedge clk); set_lights(2'b10);
    tick(1);
  endtask

  initial begin
    set_lights(2'b10);
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick(2);
    check("reset_outputs", int'(dut_vec), 0);
    @(negedge clk); reset = 1'b0;

    // single NN request through to service
    @(negedge clk); walk[1] = 1'b1;
    tick(6);
    check("nn_req_t0p5", rNN, 0);
    tick(1);
    check("nn_req_t0p6", rNN, 1);
    tick(3);
    check("nn_req_held", rNN, 1);
    check("nn_no_served", served, 0);
    @(negedge clk); walk[1] = 1'b0; lt[1] = 2'b00;
    tick(1);
    check("nn_first_red_served", served, 0);
    check("nn_first_red_req", rNN, 1);
    tick(1);
    check("nn_served_pulse", served, 3'b010);
    check("nn_req_cleared", rNN, 0);
    check("nn_count", count, 1);
    tick(1);
    check("nn_pulse_single", served, 0);
    @(negedge clk); lt[1] = 2'b10;

    // short glitches on Tv button and loop
    @(negedge clk); walk[0] = 1'b1; car[0] = 1'b1;
    repeat (3) @(negedge clk);
    walk[0] = 1'b0;
    repeat (4) @(negedge clk);
    car[0] = 1'b0;
    tick(15);
    check("tv_glitch_req", rTv, 0);
    check("tv_short_car", sTv, 0);

    // NS presence set, dropout ignored, clear
    @(negedge clk); car[2] = 1'b1;
    tick(9);
    check("ns_sensor_t0p8", sNS, 0);
    tick(1);
    check("ns_sensor_t0p9", sNS, 1);
    @(negedge clk); car[2] = 1'b0;
    @(negedge clk); car[2] = 1'b1;
    tick(12);
    check("ns_dropout", sNS, 1);
    @(negedge clk); car[2] = 1'b0;
    tick(9);
    check("ns_clear_t1p8", sNS, 1);
    tick(1);
    check("ns_clear_t1p9", sNS, 0);

    // all three served together
    @(negedge clk); walk = 3'b111;
    tick(8);
    @(negedge clk); walk = 3'b000;
    tick(8);
    check("all_pending", {rNS, rNN, rTv}, 3'b111);
    @(negedge clk); set_lights(2'b00);
    tick(2);
    check("all_served", served, 3'b111);
    check("all_count", count, 4);
    tick(1);
    check("all_pulse_single", served, 0);
    @(negedge clk); set_lights(2'b10);

    // drive the counter into saturation
    for (int r = 0; r < 83; r++) serve_round(3'b111);
    check("count_253", count, 253);
    serve_round(3'b111);
    check("count_sat", count, 255);

    // reset while NS is serving, button held through reset
    @(negedge clk); walk[2] = 1'b1;
    tick(8);
    check("ns_req_before_rst", rNS, 1);
    @(negedge clk); lt[2] = 2'b00;
    tick(1);
    @(negedge clk); reset = 1'b1;
    tick(1);
    check("mid_reset_outputs", int'(dut_vec), 0);
    tick(2);
    @(negedge clk); reset = 1'b0; lt[2] = 2'b10;
    tick(5);
    check("held_btn_early", rNS, 0);
    tick(3);
    check("held_btn_new_req", rNS, 1);
    @(negedge clk); walk[2] = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 15) == 0) walk[i] = ~walk[i];
        if ($urandom_range(0, 11) == 0) car[i] = ~car[i];
        if ($urandom_range(0, 9) == 0) lt[i] = 2'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk); reset = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
